// File: rtl/word_pkt_tx_pkg.sv
// word_pkt_tx shared types and PC-link frame mapping.
// Byte0 carries the header mark plus the top bit of every data byte.
package word_pkt_tx_pkg;

  localparam int FRAME_LEN = 5;
  localparam logic [7:0] HDR_MARK = 8'h80;

  typedef logic [FRAME_LEN-1:0][7:0] frame_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO,
    S_GAP
  } state_t;

  function automatic frame_t pkt_encode(input logic [31:0] w);
    frame_t f;
    f[0] = HDR_MARK | {4'h0, w[31], w[23], w[15], w[7]};
    f[1] = {1'b0, w[6:0]};
    f[2] = {1'b0, w[14:8]};
    f[3] = {1'b0, w[22:16]};
    f[4] = {1'b0, w[30:24]};
    return f;
  endfunction

  function automatic logic [31:0] pkt_decode(input frame_t f);
    return {f[0][3], f[4][6:0],
            f[0][2], f[3][6:0],
            f[0][1], f[2][6:0],
            f[0][0], f[1][6:0]};
  endfunction

endpackage

// File: rtl/word_pkt_tx_enc.sv
// word_pkt_enc: combinational 32-bit word to 5-byte frame builder.
// Byte i of the frame sits in frame[i].
import word_pkt_tx_pkg::*;

module word_pkt_enc (
  input  logic [31:0] word,
  output frame_t      frame
);

  assign frame = pkt_encode(word);

endmodule

// File: rtl/word_pkt_tx.sv
// word_pkt_tx: pushes a framed 32-bit word byte by byte
// into a serial transmitter using its send/busy handshake.
import word_pkt_tx_pkg::*;

module word_pkt_tx #(
  parameter int BUSY_WAIT = 16,
  parameter int GAP       = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word,
  input  logic        word_valid,
  output logic        word_ready,
  output logic [7:0]  sbyte,
  output logic        send,
  input  logic        busy,
  output logic        pkt_done,
  output logic [15:0] pkt_cnt
);

  localparam logic [7:0] WAIT_LAST = 8'(BUSY_WAIT - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP - 1);
  localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);

  state_t     state;
  frame_t     enc_frame;
  frame_t     frame_q;
  logic [2:0] idx;
  logic [7:0] wait_cnt;
  logic [7:0] gap_cnt;
  logic       adv;

  word_pkt_enc u_enc (
    .word  (word),
    .frame (enc_frame)
  );

  // A byte is finished once busy has fallen and any gap has elapsed.
  always_comb begin
    adv = 1'b0;
    if (state == S_WAIT_LO && !busy && GAP == 0)
      adv = 1'b1;
    if (state == S_GAP && gap_cnt == GAP_LAST)
      adv = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      frame_q    <= '0;
      idx        <= '0;
      wait_cnt   <= '0;
      gap_cnt    <= '0;
      word_ready <= 1'b0;
      sbyte      <= '0;
      send       <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      send     <= 1'b0;
      pkt_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!word_ready) begin
            word_ready <= 1'b1;
          end else if (word_valid) begin
            frame_q    <= enc_frame;
            idx        <= '0;
            word_ready <= 1'b0;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!busy) begin
            sbyte <= frame_q[idx];
            send  <= 1'b1;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          wait_cnt <= '0;
          state    <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          // Timeout covers transmitters that never raise busy.
          if (busy || wait_cnt == WAIT_LAST)
            state <= S_WAIT_LO;
          else
            wait_cnt <= wait_cnt + 8'd1;
        end
        S_WAIT_LO: begin
          if (!busy && GAP != 0) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 8'd1;
        end
        default: state <= S_IDLE;
      endcase

      if (adv) begin
        if (idx == LAST_IDX) begin
          pkt_done   <= 1'b1;
          pkt_cnt    <= pkt_cnt + 16'd1;
          word_ready <= 1'b1;
          state      <= S_IDLE;
        end else begin
          idx   <= idx + 3'd1;
          state <= S_LOAD;
        end
      end
    end
  end

endmodule

// File: tb/tb_word_pkt_tx.sv
// tb_word_pkt_tx: scoreboard bench for word_pkt_tx with a
// busy-driving transmitter model and per-scenario tasks.
module tb_word_pkt_tx;

  localparam int BUSY_WAIT = 16;
  localparam int GAP       = 4;
  localparam int BYTE_T    = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] word = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [7:0]  sbyte;
  logic        send;
  logic        busy;
  logic        pkt_done;
  logic [15:0] pkt_cnt;

  logic tx_busy = 1'b0;
  logic force_busy = 1'b0;
  int   tx_cnt = 0;
  bit   tx_on = 1'b0;

  assign busy = tx_busy | force_busy;

  always #5 clk = ~clk;

  word_pkt_tx #(
    .BUSY_WAIT (BUSY_WAIT),
    .GAP       (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .sbyte      (sbyte),
    .send       (send),
    .busy       (busy),
    .pkt_done   (pkt_done),
    .pkt_cnt    (pkt_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  int since = 0;
  int snd_cnt = 0;
  int done_cnt = 0;
  bit fell = 1'b0;
  bit busy_prev = 1'b0;
  bit gap_chk = 1'b0;

  // Transmitter model: busy for BYTE_T cycles after each send.
  always @(posedge clk) begin
    if (!tx_on) begin
      tx_busy <= 1'b0;
      tx_cnt  <= 0;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_busy <= 1'b0;
    end else if (send) begin
      tx_busy <= 1'b1;
      tx_cnt  <= BYTE_T;
    end
  end

  function automatic logic [7:0] enc_byte(input logic [31:0] w,
                                          input int i);
    logic [7:0] b;
    if (i == 0) b = {4'h8, w[31], w[23], w[15], w[7]};
    else b = {1'b0, w[8*i-2 -: 7]};
    return b;
  endfunction

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 5; i++) exp_q.push_back(enc_byte(w, i));
  endtask

  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (busy_prev && !busy) begin
      fell  = 1'b1;
      since = 0;
    end else begin
      since++;
    end
    if (!rst && send) begin
      snd_cnt++;
      rx_q.push_back(sbyte);
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sbyte: unexpected send, got %h, none expected",
                 sbyte);
      end else begin
        e = exp_q.pop_front();
        if (sbyte !== e) begin
          n_fail++;
          $display("FAIL sbyte: got %h, expected %h", sbyte, e);
        end
      end
      n_chk++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL send_vs_busy: busy=%b, expected 0", busy);
      end
      if (gap_chk && fell) begin
        n_chk++;
        if (since != GAP + 2) begin
          n_fail++;
          $display("FAIL gap: %0d cycles from busy fall, expected %0d",
                   since, GAP + 2);
        end
      end
      fell = 1'b0;
    end
    if (!rst && pkt_done) begin
      done_cnt++;
      fell = 1'b0;
      n_chk++;
      if (word_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL ready_at_done: word_ready=%b, expected 1",
                 word_ready);
      end
    end
    busy_prev = busy;
  end

  task automatic send_one(input logic [31:0] w, output bit to);
    @(negedge clk);
    push_word(w);
    word = w;
    word_valid = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (word_ready === 1'b1) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    word = ~w;
  endtask

  task automatic wait_done(input int target, output bit to);
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt >= target) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk += 5;
    if (word_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_ready: got %b, expected 0", word_ready);
    end
    if (send !== 1'b0) begin
      n_fail++; $display("FAIL rst_send: got %b, expected 0", send);
    end
    if (sbyte !== 8'h00) begin
      n_fail++; $display("FAIL rst_sbyte: got %h, expected 00", sbyte);
    end
    if (pkt_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_done: got %b, expected 0", pkt_done);
    end
    if (pkt_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rst_cnt: got %0d, expected 0", pkt_cnt);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (word_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_rst: got %b, expected 1", word_ready);
    end
  endtask

  task automatic test_basic;
    int lat;
    int d0;
    bit to;
    tx_on = 1'b1;
    gap_chk = 1'b1;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    push_word(32'h12345678);
    word = 32'h12345678;
    word_valid = 1'b1;
    lat = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        word_valid = 1'b0;
        word = 32'hDEADBEEF;
      end
      if (send === 1'b1 && lat < 0) lat = k;
    end
    n_chk++;
    if (lat != 2) begin
      n_fail++; $display("FAIL latency: got %0d, expected 2", lat);
    end
    wait_done(d0 + 1, to);
    repeat (10) @(negedge clk);
    n_chk += 4;
    if (to) begin
      n_fail++; $display("FAIL basic_timeout: frame not done, expected done");
    end
    if (done_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL basic_done: got %0d pulses, expected 1", done_cnt - d0);
    end
    if (pkt_cnt !== 16'd1) begin
      n_fail++; $display("FAIL basic_cnt: got %0d, expected 1", pkt_cnt);
    end
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_left: got %0d bytes pending, expected 0",
               exp_q.size());
    end
  endtask

  task automatic test_loopback;
    logic [31:0] vals[2];
    logic [31:0] angle_incr;
    bit to;
    vals[0] = 32'hFFFFFFFF;
    vals[1] = 32'h80808080;
    for (int f = 0; f < 2; f++) begin
      rx_q.delete();
      send_one(vals[f], to);
      wait_done(done_cnt + 1, to);
      @(negedge clk);
      n_chk++;
      if (to || rx_q.size() != 5) begin
        n_fail++;
        $display("FAIL loop_len: got %0d bytes, expected 5", rx_q.size());
      end else begin
        angle_incr = {rx_q[0][3], rx_q[4][6:0], rx_q[0][2], rx_q[3][6:0],
                      rx_q[0][1], rx_q[2][6:0], rx_q[0][0], rx_q[1][6:0]};
        n_chk += 2;
        if (angle_incr !== vals[f]) begin
          n_fail++;
          $display("FAIL loopback: got %h, expected %h",
                   angle_incr, vals[f]);
        end
        if (rx_q[0][7] !== 1'b1) begin
          n_fail++; $display("FAIL hdr: got %h, expected 8x", rx_q[0]);
        end
      end
    end
    n_chk++;
    if (pkt_cnt !== 16'd3) begin
      n_fail++; $display("FAIL loop_cnt: got %0d, expected 3", pkt_cnt);
    end
  endtask

  task automatic test_no_busy;
    int prev;
    int nsend;
    bit to;
    tx_on = 1'b0;
    gap_chk = 1'b0;
    send_one(32'hCAFE0123, to);
    prev = -1;
    nsend = 0;
    for (int i = 0; i < 400 && nsend < 5; i++) begin
      @(negedge clk);
      if (send === 1'b1) begin
        if (prev >= 0) begin
          n_chk++;
          if (i - prev != BUSY_WAIT + GAP + 3) begin
            n_fail++;
            $display("FAIL no_busy_period: got %0d, expected %0d",
                     i - prev, BUSY_WAIT + GAP + 3);
          end
        end
        prev = i;
        nsend++;
      end
    end
    wait_done(done_cnt + 1, to);
    n_chk += 2;
    if (nsend != 5) begin
      n_fail++; $display("FAIL no_busy_sends: got %0d, expected 5", nsend);
    end
    if (to || pkt_cnt !== 16'd4) begin
      n_fail++; $display("FAIL no_busy_cnt: got %0d, expected 4", pkt_cnt);
    end
  endtask

  task automatic test_busy_hold;
    int nsend;
    int lat;
    bit to;
    tx_on = 1'b1;
    gap_chk = 1'b0;
    force_busy = 1'b1;
    send_one(32'h0BADF00D, to);
    nsend = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (send === 1'b1) nsend++;
    end
    n_chk++;
    if (nsend != 0) begin
      n_fail++; $display("FAIL hold_send: got %0d sends, expected 0", nsend);
    end
    @(posedge clk);
    #1;
    force_busy = 1'b0;
    lat = -1;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (send === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_chk++;
    if (lat != 2) begin
      n_fail++; $display("FAIL hold_lat: got %0d, expected 2", lat);
    end
    wait_done(done_cnt + 1, to);
    n_chk++;
    if (to || pkt_cnt !== 16'd5) begin
      n_fail++; $display("FAIL hold_cnt: got %0d, expected 5", pkt_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int s0;
    int d0;
    bit to;
    tx_on = 1'b1;
    gap_chk = 1'b0;
    s0 = snd_cnt;
    send_one(32'hA5C30F96, to);
    for (int i = 0; i < 2000; i++) begin
      if (snd_cnt >= s0 + 3) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: busy=%b, expected 1", busy);
    end
    d0 = done_cnt;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    n_chk += 4;
    if (send !== 1'b0) begin
      n_fail++; $display("FAIL mid_send: got %b, expected 0", send);
    end
    if (pkt_cnt !== 16'd0) begin
      n_fail++; $display("FAIL mid_cnt: got %0d, expected 0", pkt_cnt);
    end
    if (word_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_ready: got %b, expected 0", word_ready);
    end
    if (pkt_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_done: got %b, expected 0", pkt_done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_chk += 2;
    if (word_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_ready_rel: got %b, expected 1", word_ready);
    end
    if (done_cnt != d0) begin
      n_fail++;
      $display("FAIL mid_partial: got %0d pulses, expected 0",
               done_cnt - d0);
    end
    rx_q.delete();
    send_one(32'h00000080, to);
    wait_done(d0 + 1, to);
    @(negedge clk);
    n_chk += 2;
    if (rx_q.size() == 0 || rx_q[0][7:4] !== 4'h8) begin
      n_fail++;
      $display("FAIL mid_first: got %0d bytes, first not 8x, expected 8x",
               rx_q.size());
    end
    if (to || pkt_cnt !== 16'd1) begin
      n_fail++; $display("FAIL mid_after: got %0d, expected 1", pkt_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals[3];
    logic [15:0] c0;
    int d0;
    bit to;
    vals[0] = 32'h01234567;
    vals[1] = 32'h89ABCDEF;
    vals[2] = 32'h7F00FF80;
    tx_on = 1'b1;
    gap_chk = 1'b1;
    c0 = pkt_cnt;
    d0 = done_cnt;
    rx_q.delete();
    @(negedge clk);
    word_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      word = vals[f];
      push_word(vals[f]);
      to = 1'b1;
      for (int i = 0; i < 2000; i++) begin
        if (word_ready === 1'b1) begin
          to = 1'b0;
          break;
        end
        @(negedge clk);
      end
      if (f > 0) begin
        n_chk++;
        if (to || pkt_done !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_accept: frame %0d pkt_done=%b, expected 1",
                   f, pkt_done);
        end
      end
      @(posedge clk);
      #1;
    end
    word_valid = 1'b0;
    word = 32'h0;
    wait_done(d0 + 3, to);
    @(negedge clk);
    n_chk += 3;
    if (to || pkt_cnt !== c0 + 16'd3) begin
      n_fail++;
      $display("FAIL b2b_cnt: got %0d, expected %0d", pkt_cnt, c0 + 16'd3);
    end
    if (rx_q.size() != 15) begin
      n_fail++; $display("FAIL b2b_len: got %0d, expected 15", rx_q.size());
    end
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_left: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loopback();
    test_no_busy();
    test_busy_hold();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

endmodule
